// File: rtl/bus_dma_if.sv
// Core memory bus as seen by an initiator: address/sel/write_mask/write_value out,
// read_value/ready back. An access completes in any cycle with sel_out && ready_in.
interface bus_dma_if;
  logic [31:0] address_out;
  logic        sel_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;

  modport master (
    output address_out, sel_out, write_mask_out, write_value_out,
    input  read_value_in, ready_in
  );

  modport slave (
    input  address_out, sel_out, write_mask_out, write_value_out,
    output read_value_in, ready_in
  );
endinterface

// File: rtl/bus_dma.sv
// Word copy / fill DMA engine acting as a bus initiator beside the CPU.
// One idle bus cycle separates every pair of accesses; stalled accesses abort after TIMEOUT cycles.
module bus_dma #(
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 fill,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [31:0]          fill_value,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done,
  bus_dma_if.master            bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_GAP,
    S_FINISH
  } state_t;

  localparam int unsigned          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  state_t               r_state;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [31:0]          r_data;
  logic [31:0]          r_fill_value;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_words_done;
  logic                 r_fill;
  logic                 r_after_rd;
  logic [TW-1:0]        r_tmo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic                 r_sel;
  logic [3:0]           r_mask;
  logic [31:0]          r_addr;
  logic [31:0]          r_wval;

  logic w_timeout;
  logic w_last;
  logic w_unused;

  assign w_timeout = (TIMEOUT != 0) && (r_tmo == TMO_LAST);
  assign w_last    = (r_words_done + LEN_ONE == r_len);
  assign w_unused  = &{src_addr[1:0], dst_addr[1:0]};

  assign busy                = r_busy;
  assign done                = r_done;
  assign error               = r_error;
  assign words_done          = r_words_done;
  assign bus.address_out     = r_addr;
  assign bus.sel_out         = r_sel;
  assign bus.write_mask_out  = r_mask;
  assign bus.write_value_out = r_wval;

  // NOTE: state and outputs share one clocked block and use non-blocking assignments only,
  // so every output is a flop and all branches read the pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register, datapath included, is cleared so a
    // reset mid-transfer leaves no stale address or data on the bus.
    if (!reset) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_data       <= '0;
      r_fill_value <= '0;
      r_len        <= '0;
      r_words_done <= '0;
      r_fill       <= 1'b0;
      r_after_rd   <= 1'b0;
      r_tmo        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_sel        <= 1'b0;
      r_mask       <= 4'h0;
      r_addr       <= '0;
      r_wval       <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src        <= {src_addr[31:2], 2'b00};
            r_dst        <= {dst_addr[31:2], 2'b00};
            r_len        <= len;
            r_fill       <= fill;
            r_fill_value <= fill_value;
            r_error      <= 1'b0;
            r_words_done <= '0;
            r_after_rd   <= 1'b0;
            r_tmo        <= '0;
            r_busy       <= 1'b1;
            if (len == '0) begin
              r_state <= S_FINISH;
            end else if (fill) begin
              r_state <= S_WRITE;
              r_sel   <= 1'b1;
              r_addr  <= {dst_addr[31:2], 2'b00};
              r_mask  <= 4'hF;
              r_wval  <= fill_value;
            end else begin
              r_state <= S_READ;
              r_sel   <= 1'b1;
              r_addr  <= {src_addr[31:2], 2'b00};
              r_mask  <= 4'h0;
            end
          end
        end
        S_READ: begin
          if (bus.ready_in) begin
            r_data     <= bus.read_value_in;
            r_src      <= r_src + 32'd4;
            r_sel      <= 1'b0;
            r_after_rd <= 1'b1;
            r_state    <= S_GAP;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_sel   <= 1'b0;
            r_state <= S_FINISH;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.ready_in) begin
            r_dst        <= r_dst + 32'd4;
            r_words_done <= r_words_done + LEN_ONE;
            r_sel        <= 1'b0;
            r_mask       <= 4'h0;
            r_after_rd   <= 1'b0;
            r_state      <= w_last ? S_FINISH : S_GAP;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_sel   <= 1'b0;
            r_mask  <= 4'h0;
            r_state <= S_FINISH;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_GAP: begin
          // A fetched word is always written back; abort only takes effect after a write.
          r_tmo <= '0;
          if (r_after_rd) begin
            r_state <= S_WRITE;
            r_sel   <= 1'b1;
            r_addr  <= r_dst;
            r_mask  <= 4'hF;
            r_wval  <= r_data;
          end else if (abort) begin
            r_state <= S_FINISH;
          end else if (r_fill) begin
            r_state <= S_WRITE;
            r_sel   <= 1'b1;
            r_addr  <= r_dst;
            r_mask  <= 4'hF;
            r_wval  <= r_fill_value;
          end else begin
            r_state <= S_READ;
            r_sel   <= 1'b1;
            r_addr  <= r_src;
            r_mask  <= 4'h0;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: a 1-wait memory responder plus a negedge bus monitor,
// with hand-computed expectations for copy, fill, len=0, timeout, abort, wrap and reset.
module tb_bus_dma;

  typedef struct {
    int busy;
    int done;
    int rise;
    int gap1;
    int badgap;
    int acc;
    int rd;
    int wr;
    int last_run;
  } stats_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        fill;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_done;
  logic        hang;

  bus_dma_if bus ();

  bus_dma #(.LEN_WIDTH(16), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .fill       (fill),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done),
    .bus        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Source memory is a fixed pattern; writes land in a separate destination array.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  bit [31:0]   mem [1024];
  logic [31:0] log_addr [64];
  logic [3:0]  log_mask [64];
  stats_t      st;
  stats_t      base;
  logic        prev_sel;
  logic        seen;
  int          sel_run;
  int          low_run;

  initial begin
    st       = '{default: 0};
    prev_sel = 1'b0;
    seen     = 1'b0;
    sel_run  = 0;
    low_run  = 0;
    bus.ready_in      = 1'b0;
    bus.read_value_in = '0;
  end

  // Responder: ready in the second cycle of every select, one cycle wide.
  always @(negedge clk) begin
    prev_sel <= bus.sel_out;
    if (busy) st.busy <= st.busy + 1;
    if (done) st.done <= st.done + 1;
    if (bus.sel_out) begin
      sel_run <= sel_run + 1;
      low_run <= 0;
      seen    <= 1'b1;
      if (!prev_sel) begin
        st.rise <= st.rise + 1;
        if (low_run == 1) st.gap1 <= st.gap1 + 1;
        else if (low_run != 0) st.badgap <= st.badgap + 1;
      end
      if (!hang && seen) begin
        bus.ready_in      <= 1'b1;
        bus.read_value_in <= rd_word(bus.address_out);
        st.acc <= st.acc + 1;
        if (st.acc < 64) begin
          log_addr[st.acc] <= bus.address_out;
          log_mask[st.acc] <= bus.write_mask_out;
        end
        if (bus.write_mask_out == 4'hF) begin
          st.wr <= st.wr + 1;
          mem[bus.address_out[11:2]] <= bus.write_value_out;
        end else begin
          st.rd <= st.rd + 1;
        end
      end else begin
        bus.ready_in <= 1'b0;
      end
    end else begin
      bus.ready_in <= 1'b0;
      seen         <= 1'b0;
      sel_run      <= 0;
      if (sel_run != 0) st.last_run <= sel_run;
      low_run <= busy ? low_run + 1 : 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                        input logic f, input logic [31:0] fv);
    base       = st;
    src_addr   = s;
    dst_addr   = d;
    len        = l;
    fill       = f;
    fill_value = fv;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    tick(1);
  endtask

  task automatic wait_rise(input int target, input int budget, input string tag);
    int n = 0;
    while (st.rise < target && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_rise_seen"}, (st.rise >= target), 1'b1);
  endtask

  function automatic logic [31:0] log_a(input int i);
    return (i < 64) ? log_addr[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [3:0] log_m(input int i);
    return (i < 64) ? log_mask[i] : 4'hx;
  endfunction

  int snap_wr;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; fill = 1'b0; hang = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_value = '0;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_sel", bus.sel_out, 1'b0);
    check("rst_mask", bus.write_mask_out, 4'h0);
    check("rst_addr", bus.address_out, 32'h0);
    check("rst_words", words_done, 16'h0);
    reset = 1'b1;
    tick(2);

    // Copy 3 words 0x100 -> 0x200
    launch(32'h100, 32'h200, 16'd3, 1'b0, 32'h0);
    check("copy_busy_next", busy, 1'b1);
    wait_done(100, "copy");
    check("copy_w0", mem[32'h200 >> 2], 32'hC0DE_0100);
    check("copy_w1", mem[32'h204 >> 2], 32'hC0DE_0104);
    check("copy_w2", mem[32'h208 >> 2], 32'hC0DE_0108);
    check("copy_words", words_done, 16'd3);
    check("copy_done_pulses", st.done - base.done, 1);
    check("copy_busy_cycles", st.busy - base.busy, 18);
    check("copy_reads", st.rd - base.rd, 3);
    check("copy_writes", st.wr - base.wr, 3);
    check("copy_gaps", st.gap1 - base.gap1, 5);
    check("copy_bad_gaps", st.badgap - base.badgap, 0);
    check("copy_a0", log_a(base.acc), 32'h100);
    check("copy_m0", log_m(base.acc), 4'h0);
    check("copy_a1", log_a(base.acc + 1), 32'h200);
    check("copy_m1", log_m(base.acc + 1), 4'hF);
    check("copy_error", error, 1'b0);

    // Fill 4 words at 0x400
    launch(32'h0, 32'h400, 16'd4, 1'b1, 32'hDEAD_BEEF);
    wait_done(100, "fill");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_w%0d", i), mem[(32'h400 >> 2) + i], 32'hDEAD_BEEF);
      check($sformatf("fill_m%0d", i), log_m(base.acc + i), 4'hF);
    end
    check("fill_reads", st.rd - base.rd, 0);
    check("fill_writes", st.wr - base.wr, 4);
    check("fill_gaps", st.gap1 - base.gap1, 3);
    check("fill_bad_gaps", st.badgap - base.badgap, 0);
    check("fill_busy_cycles", st.busy - base.busy, 12);
    check("fill_words", words_done, 16'd4);

    // len == 0: done two cycles after start, no bus activity
    launch(32'h100, 32'h200, 16'd0, 1'b0, 32'h0);
    check("zero_busy", busy, 1'b1);
    check("zero_done_early", done, 1'b0);
    tick(1);
    check("zero_done", done, 1'b1);
    check("zero_busy_off", busy, 1'b0);
    tick(1);
    check("zero_done_pulse", done, 1'b0);
    check("zero_rises", st.rise - base.rise, 0);
    check("zero_words", words_done, 16'd0);

    // Timeout: responder never readies
    hang = 1'b1;
    launch(32'h100, 32'h300, 16'd2, 1'b0, 32'h0);
    wait_done(100, "tmo");
    hang = 1'b0;
    check("tmo_sel_len", st.last_run, 8);
    check("tmo_error", error, 1'b1);
    check("tmo_rises", st.rise - base.rise, 1);
    check("tmo_accesses", st.acc - base.acc, 0);
    check("tmo_words", words_done, 16'd0);
    check("tmo_done_pulses", st.done - base.done, 1);
    tick(3);
    check("tmo_error_sticky", error, 1'b1);

    // Abort during 2nd read of a 5-word copy; unaligned addresses are truncated
    launch(32'h102, 32'h501, 16'd5, 1'b0, 32'h0);
    check("abort_error_cleared", error, 1'b0);
    wait_rise(base.rise + 3, 50, "abort");
    abort = 1'b1;
    wait_done(100, "abort");
    abort = 1'b0;
    check("abort_words", words_done, 16'd2);
    check("abort_reads", st.rd - base.rd, 2);
    check("abort_writes", st.wr - base.wr, 2);
    check("abort_w0", mem[32'h500 >> 2], 32'hC0DE_0100);
    check("abort_w1", mem[32'h504 >> 2], 32'hC0DE_0104);
    check("abort_w2", mem[32'h508 >> 2], 32'h0);
    check("abort_done_pulses", st.done - base.done, 1);

    // Destination address wrap
    launch(32'h0, 32'hFFFF_FFFC, 16'd2, 1'b1, 32'h1234_5678);
    wait_done(100, "wrap");
    check("wrap_a0", log_a(base.acc), 32'hFFFF_FFFC);
    check("wrap_a1", log_a(base.acc + 1), 32'h0);
    check("wrap_w0", mem[1023], 32'h1234_5678);
    check("wrap_w1", mem[0], 32'h1234_5678);

    // Start while busy is ignored; fill_value stays latched
    launch(32'h0, 32'h600, 16'd3, 1'b1, 32'h0BAD_F00D);
    tick(1);
    dst_addr = 32'h700; len = 16'd1; fill_value = 32'h1111_1111; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(100, "busy_start");
    check("busy_start_words", words_done, 16'd3);
    check("busy_start_writes", st.wr - base.wr, 3);
    check("busy_start_w2", mem[32'h608 >> 2], 32'h0BAD_F00D);
    check("busy_start_other", mem[32'h700 >> 2], 32'h0);
    tick(2);
    check("busy_start_idle", busy, 1'b0);

    // Reset in the middle of the third write
    launch(32'h0, 32'h800, 16'd8, 1'b1, 32'h5A5A_5A5A);
    wait_rise(base.rise + 3, 50, "midrst");
    check("midrst_sel_before", bus.sel_out, 1'b1);
    reset = 1'b0;
    tick(1);
    snap_wr = st.wr;
    check("midrst_sel", bus.sel_out, 1'b0);
    check("midrst_mask", bus.write_mask_out, 4'h0);
    check("midrst_addr", bus.address_out, 32'h0);
    check("midrst_wval", bus.write_value_out, 32'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_words", words_done, 16'h0);
    tick(3);
    reset = 1'b1;
    tick(10);
    check("midrst_no_writes", st.wr - snap_wr, 0);
    check("midrst_no_done", st.done - base.done, 0);
    check("midrst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
